somador_serial: RTL and testbench

Bit-serial N-bit adder: on a start pulse it latches two operands and a carry-in, then adds one bit per clock, LSB first, through a single full-adder cell. Result and carry-out are presented with a one-cycle done pulse and held until the next completed operation. It is the addition counterpart of the team's full-subtractor cell, and it can optionally subtract (see Configuration). It serves as the sequential arithmetic exercise built on the combinational adder/subtractor cells.

---
 rtl/somador_pkg.sv | 10 +
 rtl/somador_completo.sv | 12 +
 rtl/somador_serial.sv | 119 +++++++++++
 tb/tb_somador_serial.sv | 130 +++++++++++++
 4 files changed

// File: rtl/somador_pkg.sv
// somador_pkg: shared state encoding and default width for the bit-serial adder.
// Contents: state_t (IDLE/SHIFT/DONE), N_DEF default operand width.
package somador_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
   localparam int N_DEF = 8;
endpackage

// File: rtl/somador_completo.sv
// somador_completo: combinational 1-bit full adder.
// Ports: a, b, cin in; s = a^b^cin, cout = majority(a, b, cin).
module somador_completo (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/somador_serial.sv
// somador_serial: bit-serial N-bit adder, one bit per clock LSB first through a single full-adder cell.
// Ports: clk, rst (async active-high, synchronized release), start, a[N], b[N], cin,
//        sub (only with SOMADOR_SUB_EN), busy, done, s[N], cout.
// Option: define SOMADOR_SUB_EN to add the sub port; sub=1 computes a - b - cin with cout as borrow-out.
module somador_serial
   import somador_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
`ifdef SOMADOR_SUB_EN
   input  logic         sub,
`endif
   output logic         busy,
   output logic         done,
   output logic [N-1:0] s,
   output logic         cout
);
   localparam int CW = $clog2(N + 1);
   logic [1:0] rst_sync_q;
   logic rst_i;
   state_t state_q, state_d;
   logic [N-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_w;
   logic [N-2:0] r_q, r_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic c_q, c_d, cout_q, cout_d, fa_s, fa_c;
   logic [N-1:0] b_ld;
   logic c_ld, co_fix;
   // Reset asserts immediately but releases two edges later, aligned to clk.
   always_ff @(posedge clk or posedge rst)
      if (rst) rst_sync_q <= 2'b11;
      else     rst_sync_q <= {rst_sync_q[0], 1'b0};
   assign rst_i = rst_sync_q[1];
   somador_completo u_fa (
      .a   (a_q[0]),
      .b   (b_q[0]),
      .cin (c_q),
      .s   (fa_s),
      .cout(fa_c)
   );
`ifdef SOMADOR_SUB_EN
   logic sub_q, sub_d;
   // Subtraction as a + ~b + ~cin; the final carry inverted is the borrow.
   assign b_ld   = sub ? ~b : b;
   assign c_ld   = sub ? ~cin : cin;
   assign co_fix = fa_c ^ sub_q;
   assign sub_d  = (state_q == IDLE && start) ? sub : sub_q;
   always_ff @(posedge clk or posedge rst_i)
      if (rst_i) sub_q <= 1'b0;
      else       sub_q <= sub_d;
`else
   assign b_ld   = b;
   assign c_ld   = cin;
   assign co_fix = fa_c;
`endif
   // Newest sum bit enters at the MSB; after N shifts bit 0 has reached position 0.
   assign sum_w = {fa_s, r_q};
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: if (start) begin
            a_d     = a;
            b_d     = b_ld;
            c_d     = c_ld;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            r_d   = sum_w[N-1:1];
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = fa_c;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               s_d     = sum_w;
               cout_d  = co_fix;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst_i)
      if (rst_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
      end
   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_somador_serial.sv
// tb_somador_serial: directed self-checking bench for somador_serial with N=8.
module tb_somador_serial;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic cin = 1'b0;
`ifdef SOMADOR_SUB_EN
   logic sub = 1'b0;
`endif
   logic busy, done, cout;
   logic [7:0] s;
   logic [7:0] last_s = '0;
   logic last_co = 1'b0;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   somador_serial #(.N(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .cin  (cin),
`ifdef SOMADOR_SUB_EN
      .sub  (sub),
`endif
      .busy (busy),
      .done (done),
      .s    (s),
      .cout (cout)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_s"}, 32'(s), 32'h0);
      check({tag, "_cout"}, 32'(cout), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_done"}, 32'(done), 32'h0);
   endtask
   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb,
                         input int glitch, input logic [7:0] es, input logic eco);
      int nb, nd;
      @(negedge clk);
      a = av; b = bv; cin = ci; start = 1'b1;
`ifdef SOMADOR_SUB_EN
      sub = sb;
`endif
      @(negedge clk);
      start = 1'b0; a = ~av; b = 8'h5a; cin = ~ci;
`ifdef SOMADOR_SUB_EN
      sub = ~sb;
`endif
      check("s_hold", 32'(s), 32'(last_s));
      check("cout_hold", 32'(cout), 32'(last_co));
      nb = 0; nd = 0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         if (busy) nb++;
         if (done) nd++;
         start = (k == glitch);
         if (k == glitch) begin a = 8'hff; b = 8'hff; end
      end
      @(negedge clk);
      start = 1'b0;
      check("busy_cycles", 32'(nb), 32'd8);
      check("early_done", 32'(nd), 32'd0);
      check("done_pulse", 32'(done), 32'd1);
      check("busy_at_done", 32'(busy), 32'd0);
      check("sum", 32'(s), 32'(es));
      check("cout", 32'(cout), 32'(eco));
      @(negedge clk);
      check("done_fall", 32'(done), 32'd0);
      check("idle_after", 32'(busy), 32'd0);
      last_s = es; last_co = eco;
   endtask
   initial begin
      #2;
      check_zero("reset_init");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("post_release");
      run_op(8'h05, 8'h03, 1'b0, 1'b0, -1, 8'h08, 1'b0);
      @(posedge clk); #3;
      rst = 1'b1; #1;
      check_zero("async_rst");
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      last_s = 8'h00; last_co = 1'b0;
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, -1, 8'h00, 1'b1);
      repeat (3) @(negedge clk);
      check("idle_s_hold", 32'(s), 32'h00);
      check("idle_cout_hold", 32'(cout), 32'h1);
      run_op(8'hFF, 8'hFF, 1'b1, 1'b0, -1, 8'hFF, 1'b1);
      run_op(8'h12, 8'h34, 1'b0, 1'b0, 3, 8'h46, 1'b0);
      @(negedge clk);
      check("glitch_no_restart", 32'(busy), 32'd0);
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1; #1;
      check_zero("mid_rst");
      @(negedge clk); rst = 1'b0;
      begin
         int nd = 0;
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) nd++;
         end
         check("aborted_no_done", 32'(nd), 32'd0);
      end
      check_zero("after_abort");
      last_s = 8'h00; last_co = 1'b0;
      run_op(8'h0A, 8'h0B, 1'b1, 1'b0, -1, 8'h16, 1'b0);
`ifdef SOMADOR_SUB_EN
      run_op(8'h05, 8'h07, 1'b0, 1'b1, -1, 8'hFE, 1'b1);
      run_op(8'h07, 8'h05, 1'b1, 1'b1, -1, 8'h01, 1'b0);
      run_op(8'h07, 8'h05, 1'b1, 1'b0, -1, 8'h0D, 1'b0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
